// File: rtl/eb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eb_pkg
// Description : Shared definitions for the RX elastic buffer (read and write
//               side controllers): SKP ordered-set symbol, read FSM state
//               encoding and Gray/binary pointer conversion helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package eb_pkg;

    // K28.0, the SKP symbol that may be duplicated or dropped.
    localparam logic [7:0] SKP_SYM = 8'h1C;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        RUN  = 1'b1
    } eb_state_e;

    // The conversions operate on a 32-bit zero-extended pointer, so they serve
    // any PTR_WIDTH up to 32; callers cast the result back to PTR_WIDTH.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 1; i < 32; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage : eb_pkg
`default_nettype wire

// File: rtl/eb_rd_ptr.sv
`default_nettype none
// ============================================================================
// Module      : eb_rd_ptr
// Description : Read pointer register pair. Holds the binary read pointer and
//               its registered Gray copy, updated together so the Gray output
//               never glitches into the write clock domain.
// Ports       : clk, rst        - clock, async active-high reset
//               inc_i           - advance pointer by one (wraps)
//               load_i          - load load_val_i (has priority over inc_i)
//               load_val_i      - binary value to load
//               rd_bin_o        - binary read pointer (registered)
//               rd_ptr_gray_o   - Gray read pointer (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module eb_rd_ptr #(
    parameter int PTR_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc_i,
    input  logic                 load_i,
    input  logic [PTR_WIDTH-1:0] load_val_i,
    output logic [PTR_WIDTH-1:0] rd_bin_o,
    output logic [PTR_WIDTH-1:0] rd_ptr_gray_o
);
    import eb_pkg::*;

    logic [PTR_WIDTH-1:0] rd_bin_q;
    logic [PTR_WIDTH-1:0] rd_bin_d;
    logic [PTR_WIDTH-1:0] rd_gray_q;

    always_comb begin
        rd_bin_d = rd_bin_q;
        if (load_i) begin
            rd_bin_d = load_val_i;
        end else if (inc_i) begin
            rd_bin_d = rd_bin_q + PTR_WIDTH'(1);
        end
    end

    // Gray copy is computed from the next binary value so both registers
    // always describe the same pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_bin_q  <= '0;
            rd_gray_q <= '0;
        end else begin
            rd_bin_q  <= rd_bin_d;
            rd_gray_q <= PTR_WIDTH'(bin2gray(32'(rd_bin_d)));
        end
    end

    assign rd_bin_o      = rd_bin_q;
    assign rd_ptr_gray_o = rd_gray_q;

endmodule : eb_rd_ptr
`default_nettype wire

// File: rtl/eb_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : eb_rd_ctrl
// Description : Read-side controller of the RX elastic buffer (core clock).
//               Waits for START_LVL entries, then streams symbols out of the
//               buffer RAM, duplicating a SKP when the fill is low and
//               dropping one when it is high. Recovers from underflow (wait
//               for refill) and overflow (flush to the write pointer).
// Ports       : clk, rst          - clock, async active-high reset
//               wr_ptr_gray_sync  - write pointer, Gray, synchronized here
//               rd_data, rd_is_k  - RAM read data at rd_addr (comb. read)
//               rd_addr           - RAM read address
//               rd_ptr_gray       - registered Gray read pointer
//               out_data/out_k    - output symbol and K flag
//               out_valid         - output qualifier
//               fill_level        - registered fill
//               skp_added/skp_removed/underflow/overflow - event pulses
// Revision    : 1.0 - initial release
// ============================================================================
module eb_rd_ctrl #(
    parameter int PTR_WIDTH  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int LOW_WM     = 2,
    parameter int HIGH_WM    = 6,
    parameter int START_LVL  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PTR_WIDTH-1:0]  wr_ptr_gray_sync,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_is_k,
    output logic [PTR_WIDTH-2:0]  rd_addr,
    output logic [PTR_WIDTH-1:0]  rd_ptr_gray,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_k,
    output logic                  out_valid,
    output logic [PTR_WIDTH-1:0]  fill_level,
    output logic                  skp_added,
    output logic                  skp_removed,
    output logic                  underflow,
    output logic                  overflow
);
    import eb_pkg::*;

    localparam int                   DEPTH   = 2 ** (PTR_WIDTH - 1);
    localparam logic [PTR_WIDTH-1:0] DEPTH_V = PTR_WIDTH'(DEPTH);
    localparam logic [PTR_WIDTH-1:0] START_V = PTR_WIDTH'(START_LVL);
    localparam logic [PTR_WIDTH-1:0] LOW_V   = PTR_WIDTH'(LOW_WM);
    localparam logic [PTR_WIDTH-1:0] HIGH_V  = PTR_WIDTH'(HIGH_WM);

    eb_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_k_q, out_k_d;
    logic                  out_valid_q, out_valid_d;
    logic [PTR_WIDTH-1:0]  fill_level_q;
    logic                  skp_added_q, skp_added_d;
    logic                  skp_removed_q, skp_removed_d;
    logic                  underflow_q, underflow_d;
    logic                  overflow_q, overflow_d;
    logic                  ins_done_q, ins_done_d;
    logic                  rem_done_q, rem_done_d;

    logic [PTR_WIDTH-1:0]  wr_bin;
    logic [PTR_WIDTH-1:0]  rd_bin;
    logic [PTR_WIDTH-1:0]  fill;
    logic                  is_skp;
    logic                  ptr_inc;
    logic                  ptr_load;

    eb_rd_ptr #(
        .PTR_WIDTH (PTR_WIDTH)
    ) u_rd_ptr (
        .clk           (clk),
        .rst           (rst),
        .inc_i         (ptr_inc),
        .load_i        (ptr_load),
        .load_val_i    (wr_bin),
        .rd_bin_o      (rd_bin),
        .rd_ptr_gray_o (rd_ptr_gray)
    );

    assign wr_bin  = PTR_WIDTH'(gray2bin(32'(wr_ptr_gray_sync)));
    // Modulo subtraction: values above DEPTH can only mean the writer lapped us.
    assign fill    = wr_bin - rd_bin;
    assign is_skp  = rd_is_k && (rd_data == DATA_WIDTH'(SKP_SYM));
    assign rd_addr = rd_bin[PTR_WIDTH-2:0];

    always_comb begin
        state_d       = state_q;
        ptr_inc       = 1'b0;
        ptr_load      = 1'b0;
        out_valid_d   = 1'b0;
        out_data_d    = '0;
        out_k_d       = 1'b0;
        skp_added_d   = 1'b0;
        skp_removed_d = 1'b0;
        underflow_d   = 1'b0;
        overflow_d    = 1'b0;
        ins_done_d    = ins_done_q;
        rem_done_d    = 1'b0;

        case (state_q)
            FILL: begin
                if ((fill >= START_V) && (fill <= DEPTH_V)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (fill > DEPTH_V) begin
                    overflow_d = 1'b1;
                    ptr_load   = 1'b1;
                    state_d    = FILL;
                end else if (fill == '0) begin
                    underflow_d = 1'b1;
                    state_d     = FILL;
                end else if (is_skp && (fill >= HIGH_V) && !rem_done_q) begin
                    // Checked before insertion so removal wins when the
                    // watermarks overlap.
                    ptr_inc       = 1'b1;
                    skp_removed_d = 1'b1;
                    rem_done_d    = 1'b1;
                end else if (is_skp && (fill <= LOW_V) && !ins_done_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = rd_data;
                    out_k_d     = rd_is_k;
                    skp_added_d = 1'b1;
                    ins_done_d  = 1'b1;
                end else begin
                    out_valid_d = 1'b1;
                    out_data_d  = rd_data;
                    out_k_d     = rd_is_k;
                    ptr_inc     = 1'b1;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase

        // A new head symbol may be duplicated again.
        if (ptr_inc || ptr_load) begin
            ins_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FILL;
            out_data_q    <= '0;
            out_k_q       <= 1'b0;
            out_valid_q   <= 1'b0;
            fill_level_q  <= '0;
            skp_added_q   <= 1'b0;
            skp_removed_q <= 1'b0;
            underflow_q   <= 1'b0;
            overflow_q    <= 1'b0;
            ins_done_q    <= 1'b0;
            rem_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            out_data_q    <= out_data_d;
            out_k_q       <= out_k_d;
            out_valid_q   <= out_valid_d;
            fill_level_q  <= fill;
            skp_added_q   <= skp_added_d;
            skp_removed_q <= skp_removed_d;
            underflow_q   <= underflow_d;
            overflow_q    <= overflow_d;
            ins_done_q    <= ins_done_d;
            rem_done_q    <= rem_done_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_k       = out_k_q;
    assign out_valid   = out_valid_q;
    assign fill_level  = fill_level_q;
    assign skp_added   = skp_added_q;
    assign skp_removed = skp_removed_q;
    assign underflow   = underflow_q;
    assign overflow    = overflow_q;

endmodule : eb_rd_ctrl
`default_nettype wire

// File: tb/tb_eb_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_eb_rd_ctrl
// Description : Self-checking bench for eb_rd_ctrl. The bench owns the buffer
//               RAM and the write pointer, and predicts every output with a
//               cycle-level reference model of the read-side rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eb_rd_ctrl;

    localparam int N_ENT  = 8;   // buffer entries
    localparam int N_PTR  = 16;  // pointer range incl. wrap bit
    localparam int M_LOW  = 2;
    localparam int M_HIGH = 6;
    localparam int M_STRT = 4;

    logic       clk;
    logic       rst;
    logic [3:0] wr_ptr_gray_sync;
    logic [7:0] rd_data;
    logic       rd_is_k;
    logic [2:0] rd_addr;
    logic [3:0] rd_ptr_gray;
    logic [7:0] out_data;
    logic       out_k;
    logic       out_valid;
    logic [3:0] fill_level;
    logic       skp_added;
    logic       skp_removed;
    logic       underflow;
    logic       overflow;

    eb_rd_ctrl #(
        .PTR_WIDTH  (4),
        .DATA_WIDTH (8),
        .LOW_WM     (M_LOW),
        .HIGH_WM    (M_HIGH),
        .START_LVL  (M_STRT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .wr_ptr_gray_sync (wr_ptr_gray_sync),
        .rd_data          (rd_data),
        .rd_is_k          (rd_is_k),
        .rd_addr          (rd_addr),
        .rd_ptr_gray      (rd_ptr_gray),
        .out_data         (out_data),
        .out_k            (out_k),
        .out_valid        (out_valid),
        .fill_level       (fill_level),
        .skp_added        (skp_added),
        .skp_removed      (skp_removed),
        .underflow        (underflow),
        .overflow         (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer RAM with combinational read
    logic [7:0] mem  [N_ENT];
    logic       kmem [N_ENT];
    assign rd_data = mem[rd_addr];
    assign rd_is_k = kmem[rd_addr];

    int n_cmp;
    int n_fail;

    // Write side and reference model state
    int          wr;
    bit          m_run;
    int          m_rd;
    bit          m_ins;
    bit          m_rem;
    logic [24:0] exp_vec;

    function automatic logic [3:0] to_gray(input int b);
        return 4'(b ^ (b >> 1));
    endfunction

    // {valid, data, k, rd_ptr_gray, rd_addr, fill_level, added, removed, unf, ovf}
    function automatic logic [24:0] obs_vec();
        return {out_valid, out_valid ? out_data : 8'h00, out_valid ? out_k : 1'b0,
                rd_ptr_gray, rd_addr, fill_level,
                skp_added, skp_removed, underflow, overflow};
    endfunction

    task automatic push_sym(input logic [7:0] d, input logic k);
        mem[wr % N_ENT]  = d;
        kmem[wr % N_ENT] = k;
        wr               = (wr + 1) % N_PTR;
        wr_ptr_gray_sync = to_gray(wr);
    endtask

    task automatic push(input int n, input int skp_pct);
        logic [7:0] d;
        logic       k;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(99) < skp_pct) begin
                d = 8'h1C;
                k = 1'b1;
            end else begin
                d = 8'($urandom);
                k = ($urandom_range(9) == 0);
                if (k && d == 8'h1C) d = 8'hBC;
            end
            push_sym(d, k);
        end
    endtask

    // Predict the outcome of the next edge from the fill the reader sees now,
    // then advance one clock and settle.
    task automatic step();
        int         fill;
        int         a;
        bit         skp;
        bit         v, ad, rm, uf, of;
        logic [7:0] d;
        logic       k;
        fill = (wr - m_rd) & (N_PTR - 1);
        a    = m_rd % N_ENT;
        v = 0; ad = 0; rm = 0; uf = 0; of = 0; d = 8'h00; k = 1'b0;
        if (!m_run) begin
            if (fill >= M_STRT && fill <= N_ENT) m_run = 1;
            m_rem = 0;
        end else if (fill > N_ENT) begin
            of = 1; m_rd = wr; m_run = 0; m_ins = 0; m_rem = 0;
        end else if (fill == 0) begin
            uf = 1; m_run = 0; m_rem = 0;
        end else begin
            skp = kmem[a] && (mem[a] == 8'h1C);
            if (skp && fill >= M_HIGH && !m_rem) begin
                rm = 1; m_rd = (m_rd + 1) % N_PTR; m_rem = 1; m_ins = 0;
            end else if (skp && fill <= M_LOW && !m_ins) begin
                v = 1; d = mem[a]; k = kmem[a]; ad = 1; m_ins = 1; m_rem = 0;
            end else begin
                v = 1; d = mem[a]; k = kmem[a];
                m_rd = (m_rd + 1) % N_PTR; m_ins = 0; m_rem = 0;
            end
        end
        exp_vec = {v, d, k, to_gray(m_rd), 3'(m_rd % N_ENT), 4'(fill), ad, rm, uf, of};
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        wr  = 0;
        wr_ptr_gray_sync = 4'h0;
        for (int i = 0; i < N_ENT; i++) begin
            mem[i]  = 8'h00;
            kmem[i] = 1'b0;
        end
        m_run = 0; m_rd = 0; m_ins = 0; m_rem = 0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wr  = 0;
        wr_ptr_gray_sync = 4'h0;
        #1;
        n_cmp++;
        if (obs_vec() !== 25'h0) begin
            n_fail++;
            $display("FAIL reset_async: got %h required %h", obs_vec(), 25'h0);
        end
        reset_dut();
        n_cmp++;
        if (obs_vec() !== 25'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h required %h", obs_vec(), 25'h0);
        end
    endtask

    task automatic test_startup();
        int    wraps;
        logic [2:0] prev;
        reset_dut();
        wraps = 0;
        prev  = rd_addr;
        for (int i = 0; i < 30; i++) begin
            push(1, 0);
            step();
            n_cmp++;
            if (obs_vec() !== exp_vec) begin
                n_fail++;
                $display("FAIL startup_model cyc %0d: got %h required %h", i, obs_vec(), exp_vec);
            end
            if (i == 3) begin
                n_cmp++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL startup_early: out_valid %b required 0", out_valid);
                end
            end
            if (i == 4) begin
                n_cmp++;
                if (out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL startup_latency: out_valid %b required 1", out_valid);
                end
            end
            if (prev == 3'd7 && rd_addr == 3'd0) wraps++;
            prev = rd_addr;
        end
        n_cmp++;
        if (wraps != 3) begin
            n_fail++;
            $display("FAIL addr_wrap: wraps %0d required 3", wraps);
        end
    endtask

    task automatic test_skp_insert();
        int n_add, n_skp_out, n_unf, n_val;
        reset_dut();
        push_sym(8'h11, 1'b0);
        push_sym(8'h22, 1'b0);
        push_sym(8'h1C, 1'b1);
        push_sym(8'h44, 1'b0);
        n_add = 0; n_skp_out = 0; n_unf = 0; n_val = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if (obs_vec() !== exp_vec) begin
                n_fail++;
                $display("FAIL insert_model cyc %0d: got %h required %h", i, obs_vec(), exp_vec);
            end
            if (i == 3) begin
                n_cmp++;
                if (rd_addr !== 3'd2 || skp_added !== 1'b1) begin
                    n_fail++;
                    $display("FAIL insert_hold: rd_addr %0d added %b required 2 1", rd_addr, skp_added);
                end
            end
            n_add     += int'(skp_added);
            n_unf     += int'(underflow);
            n_val     += int'(out_valid);
            n_skp_out += int'(out_valid && out_k && out_data == 8'h1C);
        end
        n_cmp++;
        if (n_add != 1 || n_skp_out != 2 || n_unf != 1 || n_val != 5) begin
            n_fail++;
            $display("FAIL insert_counts: add %0d skp %0d unf %0d val %0d required 1 2 1 5",
                     n_add, n_skp_out, n_unf, n_val);
        end
        // Refill: nothing may come out until the fill is back at the start level.
        push(3, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (out_valid !== 1'b0 || obs_vec() !== exp_vec) begin
                n_fail++;
                $display("FAIL refill_wait cyc %0d: got %h required %h", i, obs_vec(), exp_vec);
            end
        end
        push(1, 0);
        step();
        step();
        n_cmp++;
        if (out_valid !== 1'b1 || obs_vec() !== exp_vec) begin
            n_fail++;
            $display("FAIL refill_resume: got %h required %h", obs_vec(), exp_vec);
        end
    endtask

    task automatic test_skp_remove();
        logic prev_rm;
        reset_dut();
        push_sym(8'h1C, 1'b1);
        push_sym(8'h1C, 1'b1);
        push(4, 0);
        step();  // FILL -> RUN at fill 6
        prev_rm = 1'b0;
        for (int i = 0; i < 14; i++) begin
            push(1, (i < 2) ? 0 : 50);
            step();
            n_cmp++;
            if (obs_vec() !== exp_vec) begin
                n_fail++;
                $display("FAIL remove_model cyc %0d: got %h required %h", i, obs_vec(), exp_vec);
            end
            if (i == 0) begin
                n_cmp++;
                if (skp_removed !== 1'b1 || out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL remove_first: removed %b valid %b required 1 0", skp_removed, out_valid);
                end
            end
            if (i == 1) begin
                n_cmp++;
                if (skp_removed !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h1C) begin
                    n_fail++;
                    $display("FAIL remove_second: removed %b valid %b data %h required 0 1 1c",
                             skp_removed, out_valid, out_data);
                end
            end
            n_cmp++;
            if (prev_rm && skp_removed) begin
                n_fail++;
                $display("FAIL remove_b2b: removed %b after removal required 0", skp_removed);
            end
            prev_rm = skp_removed;
        end
    endtask

    task automatic test_overflow();
        reset_dut();
        push(4, 0);
        step();
        step();
        wr = (m_rd + 9) % N_PTR;
        wr_ptr_gray_sync = to_gray(wr);
        step();
        n_cmp++;
        if (overflow !== 1'b1 || out_valid !== 1'b0 || rd_ptr_gray !== wr_ptr_gray_sync) begin
            n_fail++;
            $display("FAIL overflow_flush: ovf %b valid %b gray %h required 1 0 %h",
                     overflow, out_valid, rd_ptr_gray, wr_ptr_gray_sync);
        end
        n_cmp++;
        if (obs_vec() !== exp_vec) begin
            n_fail++;
            $display("FAIL overflow_model: got %h required %h", obs_vec(), exp_vec);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (out_valid !== 1'b0 || overflow !== 1'b0 || obs_vec() !== exp_vec) begin
                n_fail++;
                $display("FAIL overflow_after cyc %0d: got %h required %h", i, obs_vec(), exp_vec);
            end
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        push_sym(8'h31, 1'b0);
        push_sym(8'h32, 1'b0);
        push_sym(8'h1C, 1'b1);
        push_sym(8'h34, 1'b0);
        step();
        step();
        step();  // SKP now at head with fill at the low watermark
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (obs_vec() !== 25'h0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %h required %h", obs_vec(), 25'h0);
        end
        wr = 0;
        wr_ptr_gray_sync = 4'h0;
        m_run = 0; m_rd = 0; m_ins = 0; m_rem = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push(1, 0);
            step();
            n_cmp++;
            if (obs_vec() !== exp_vec) begin
                n_fail++;
                $display("FAIL reset_mid_restart cyc %0d: got %h required %h", i, obs_vec(), exp_vec);
            end
            if (i == 4) begin
                n_cmp++;
                if (out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL reset_mid_latency: out_valid %b required 1", out_valid);
                end
            end
        end
    endtask

    task automatic test_random();
        int n;
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99) < 3) n = $urandom_range(4, 9);
            else if ($urandom_range(9) < 5) n = 1;
            else n = 2 * $urandom_range(1);
            push(n, 30);
            step();
            n_cmp++;
            if (obs_vec() !== exp_vec) begin
                n_fail++;
                $display("FAIL random_model cyc %0d: got %h required %h", i, obs_vec(), exp_vec);
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        wr     = 0;
        wr_ptr_gray_sync = 4'h0;
        exp_vec = '0;
        test_reset();
        test_startup();
        test_skp_insert();
        test_skp_remove();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_eb_rd_ctrl
`default_nettype wire
